mem_bus_responder: RTL and testbench
====================================

# mem_bus_responder

Main-memory responder for the common bus of the 4-core MESI cache system. It is the memory end of the `BusRd`/`BusRdX`/`Mem_wr` transactions that the L1 caches issue after arbitration. It returns read data with a configurable latency and commits writebacks, raising `Mem_write_done`. It also honours `Mem_oprn_abort` when a snooping cache supplies the line instead of memory. It replaces the ad-hoc memory stubs in the multicore bench and sits beside `arbiter` under `cache_multi_config_1`.

## Interface
- `ADDR_W`, 32, common-bus address width.
- `DATA_W`, 32, common-bus data width (one word per transaction).
- `DEPTH_LOG2`, 10, log2 of the word count; the index is `Address_Com[DEPTH_LOG2+1:2]`.
- `RD_LATENCY`, 4, cycles from read acceptance to data valid; legal range 1..15.
- `WR_LATENCY`, 4, cycles from write acceptance to commit; legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `BusRd`  in  1  read request, level, held until response or abort.
- `BusRdX`  in  1  read-for-ownership request; the memory treats it identically to `BusRd`.
- `Mem_wr`  in  1  write (writeback) request, level, held until `Mem_write_done`.
- `Mem_oprn_abort`  in  1  a cache supplies data; cancel the pending operation.
- `Address_Com`  in  ADDR_W  transaction address.
- `Data_Bus_Com_in`  in  DATA_W  write data from the bus.
- `Data_Bus_Com_out`  out  DATA_W  read data to the bus.
- `Data_Bus_Com_oe`  out  1  bus drive enable for `Data_Bus_Com_out`.
- `Data_in_Bus`  out  1  read data valid on the bus.
- `Mem_write_done`  out  1  write committed.
- `abort_cnt`  out  16  saturating count of aborted operations (debug).

## Operation
- FSM states: `IDLE`, `RD_WAIT`, `RD_DRIVE`, `WR_WAIT`, `WR_DONE`.
- In `IDLE`:
  - `Mem_wr`=1 latches the address and `Data_Bus_Com_in`, loads the counter with `WR_LATENCY-1`, and moves to `WR_WAIT`.
  - Otherwise, `BusRd|BusRdX`=1 latches the address, loads the counter with `RD_LATENCY-1`, and moves to `RD_WAIT`.
  - If `Mem_wr` and a read are asserted together, the write wins.
  - A request with `Mem_oprn_abort`=1 in the same cycle is ignored.
- `RD_WAIT`: the counter decrements. At 0 the FSM moves to `RD_DRIVE`, and the data register loads the word at the latched index.
- `RD_DRIVE`: `Data_in_Bus`=1, `Data_Bus_Com_oe`=1, and data is held stable. When `BusRd` and `BusRdX` are both low, the FSM returns to `IDLE`.
- `WR_WAIT`: the counter decrements. At 0 the array is written, the valid bit is set, and the FSM moves to `WR_DONE`.
- `WR_DONE`: `Mem_write_done`=1 until `Mem_wr`=0, then `IDLE`.
- Abort: `Mem_oprn_abort`=1 in `RD_WAIT`, `RD_DRIVE` or `WR_WAIT` returns the FSM to `IDLE` at the next edge.
  - No write is committed and no data is driven afterwards.
  - `abort_cnt` increments, saturating at 0xFFFF.
  - Abort in `WR_DONE` is ignored because the write has already committed.
- Requester drop: `BusRd`/`BusRdX` falling during `RD_WAIT`, or `Mem_wr` falling during `WR_WAIT`, is treated as an abort (counted).
- Unwritten words: a per-word valid bit, cleared by reset, marks each location. A read of an invalid word returns `{Address_Com[ADDR_W-1:2],2'b00}` truncated or zero-extended to `DATA_W`.
- Array contents are not reset; only the valid bits are.

## Timing
- Reset values: state `IDLE`, counter 0, `Data_in_Bus`=0, `Data_Bus_Com_oe`=0, `Data_Bus_Com_out`=0, `Mem_write_done`=0, `abort_cnt`=0, all valid bits 0.
- Reset asserted mid-transaction: all outputs drop immediately (asynchronous). An in-flight write is lost.
- Read: request sampled at edge N, so `Data_in_Bus`=1 after edge N+`RD_LATENCY`. It falls one cycle after the request is seen low.
- Write: `Mem_wr` sampled at edge N, so the commit and `Mem_write_done`=1 occur after edge N+`WR_LATENCY`.
- Back-to-back: a new request is accepted no earlier than the cycle after the return to `IDLE`, giving a minimum gap of one idle cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- The counter is 4 bits wide and must never wrap, because latencies are bounded at 15.

## Structure
- Package `mem_resp_pkg`: state enum `mem_resp_state_t`, and the `MAX_LATENCY`=15 constant.
- Sub-module `mem_word_array`: synchronous-write, registered-read word store with its valid-bit vector. Its ports are write enable, write index, write data, read index, read data, read valid, and `rst_n` (valid bits only).
- Top: FSM, latency counter, address and data latches, abort counter.

## Test plan
- Write `0xDEADBEEC` ← `0xCAFEF00D` with `WR_LATENCY`=4 → `Mem_write_done` rises 4 cycles after acceptance. A subsequent `BusRd` at the same address → `Data_in_Bus` rises 4 cycles after acceptance with `0xCAFEF00D`.
- `BusRdX` to never-written `0x00001234` → data `0x00001234`, `Data_Bus_Com_oe`=1 while valid.
- `BusRd` then `Mem_oprn_abort` pulsed in cycle 2 of `RD_WAIT` → no `Data_in_Bus`, return to `IDLE`, `abort_cnt`=1.
- Abort during `WR_WAIT` for `0x40` ← `0x11111111` → the later read of `0x40` returns `0x00000040` (write discarded).
- `Mem_wr` and `BusRd` asserted in the same cycle → write serviced first, read accepted after its completion.
- `rst_n` low during `RD_DRIVE` → outputs 0 immediately and valid bits cleared, so the previously written address reads back its own address.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types for the main-memory bus responder: FSM state encoding and latency bounds.
// Latency counter is 4 bits; loads are clamped so it can never wrap.
package mem_resp_pkg;

   localparam int MAX_LATENCY = 15;
   localparam int CNT_W       = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT  = 3'd1,
      RD_DRIVE = 3'd2,
      WR_WAIT  = 3'd3,
      WR_DONE  = 3'd4
   } mem_resp_state_t;

   function automatic logic [CNT_W-1:0] lat_load(input int lat);
      int clamped;
      clamped = (lat > MAX_LATENCY) ? MAX_LATENCY : ((lat < 1) ? 1 : lat);
      return CNT_W'(clamped - 1);
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word store: synchronous write, registered read (1 cycle), per-word valid bits cleared by reset.
// No backpressure; contents are not reset, only the valid vector.
module mem_word_array
   import mem_resp_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en_i,
   input  logic [DEPTH_LOG2-1:0] wr_idx_i,
   input  logic [DATA_W-1:0]     wr_dat_i,
   input  logic [DEPTH_LOG2-1:0] rd_idx_i,
   output logic [DATA_W-1:0]     rd_dat_o,
   output logic                  rd_vld_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  vld_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_dat_i;
      end
      rd_dat_o <= mem_q[rd_idx_i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q    <= '0;
         rd_vld_o <= 1'b0;
      end else begin
         if (wr_en_i) begin
            vld_q[wr_idx_i] <= 1'b1;
         end
         rd_vld_o <= vld_q[rd_idx_i];
      end
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory end of the common bus: reads return after RD_LATENCY edges, writes commit after WR_LATENCY.
// Level handshakes: requests held until response; abort or requester drop cancels and is counted.
module mem_bus_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 10,
   parameter int RD_LATENCY = 4,
   parameter int WR_LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              BusRd,
   input  logic              BusRdX,
   input  logic              Mem_wr,
   input  logic              Mem_oprn_abort,
   input  logic [ADDR_W-1:0] Address_Com,
   input  logic [DATA_W-1:0] Data_Bus_Com_in,
   output logic [DATA_W-1:0] Data_Bus_Com_out,
   output logic              Data_Bus_Com_oe,
   output logic              Data_in_Bus,
   output logic              Mem_write_done,
   output logic [15:0]       abort_cnt
);

   localparam logic [CNT_W-1:0] RD_LOAD = lat_load(RD_LATENCY);
   localparam logic [CNT_W-1:0] WR_LOAD = lat_load(WR_LATENCY);

   mem_resp_state_t   state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-3:0] addr_q;
   logic [DATA_W-1:0] wdat_q;
   logic [DATA_W-1:0] data_q;
   logic              dib_q;
   logic              oe_q;
   logic              done_q;
   logic [15:0]       abort_cnt_q;

   logic                  rd_req;
   logic                  abort_ev;
   logic                  commit;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic [DATA_W-1:0]     arr_dat;
   logic                  arr_vld;
   logic [DATA_W-1:0]     rd_word;
   logic                  unused_addr_lsb;

   assign unused_addr_lsb = ^Address_Com[1:0];
   assign rd_req          = BusRd | BusRdX;

   // Cancellation: explicit abort, or the requester letting go before we finish.
   assign abort_ev = ((state_q == RD_WAIT)  && (Mem_oprn_abort || !rd_req)) ||
                     ((state_q == RD_DRIVE) &&  Mem_oprn_abort)              ||
                     ((state_q == WR_WAIT)  && (Mem_oprn_abort || !Mem_wr));

   assign commit = (state_q == WR_WAIT) && (cnt_q == '0) && !abort_ev;

   // Index the array from the live bus while idle so a latency of 1 still sees the right word.
   assign rd_idx = (state_q == IDLE) ? Address_Com[DEPTH_LOG2+1:2] : addr_q[DEPTH_LOG2-1:0];

   assign rd_word = arr_vld ? arr_dat : DATA_W'({addr_q, 2'b00});

   mem_word_array #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en_i  (commit),
      .wr_idx_i (addr_q[DEPTH_LOG2-1:0]),
      .wr_dat_i (wdat_q),
      .rd_idx_i (rd_idx),
      .rd_dat_o (arr_dat),
      .rd_vld_o (arr_vld)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdat_q      <= '0;
         data_q      <= '0;
         dib_q       <= 1'b0;
         oe_q        <= 1'b0;
         done_q      <= 1'b0;
         abort_cnt_q <= '0;
      end else begin
         if (abort_ev && (abort_cnt_q != 16'hFFFF)) begin
            abort_cnt_q <= abort_cnt_q + 16'd1;
         end
         unique case (state_q)
            IDLE: begin
               if (!Mem_oprn_abort) begin
                  if (Mem_wr) begin
                     addr_q  <= Address_Com[ADDR_W-1:2];
                     wdat_q  <= Data_Bus_Com_in;
                     cnt_q   <= WR_LOAD;
                     state_q <= WR_WAIT;
                  end else if (rd_req) begin
                     addr_q  <= Address_Com[ADDR_W-1:2];
                     cnt_q   <= RD_LOAD;
                     state_q <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (abort_ev) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (cnt_q == '0) begin
                  data_q  <= rd_word;
                  dib_q   <= 1'b1;
                  oe_q    <= 1'b1;
                  state_q <= RD_DRIVE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RD_DRIVE: begin
               if (Mem_oprn_abort || !rd_req) begin
                  data_q  <= '0;
                  dib_q   <= 1'b0;
                  oe_q    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            WR_WAIT: begin
               if (abort_ev) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (cnt_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= WR_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            WR_DONE: begin
               if (!Mem_wr) begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Data_Bus_Com_out = data_q;
   assign Data_Bus_Com_oe  = oe_q;
   assign Data_in_Bus      = dib_q;
   assign Mem_write_done   = done_q;
   assign abort_cnt        = abort_cnt_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: latencies, invalid-word reads, aborts, write priority, async reset.
module tb_mem_bus_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        BusRd, BusRdX, Mem_wr, Mem_oprn_abort;
   logic [31:0] Address_Com, Data_Bus_Com_in;
   logic [31:0] Data_Bus_Com_out;
   logic        Data_Bus_Com_oe, Data_in_Bus, Mem_write_done;
   logic [15:0] abort_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;
   bit saw_dib;

   always #5 clk = ~clk;

   mem_bus_responder #(
      .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(10), .RD_LATENCY(4), .WR_LATENCY(4)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .BusRd            (BusRd),
      .BusRdX           (BusRdX),
      .Mem_wr           (Mem_wr),
      .Mem_oprn_abort   (Mem_oprn_abort),
      .Address_Com      (Address_Com),
      .Data_Bus_Com_in  (Data_Bus_Com_in),
      .Data_Bus_Com_out (Data_Bus_Com_out),
      .Data_Bus_Com_oe  (Data_Bus_Com_oe),
      .Data_in_Bus      (Data_in_Bus),
      .Mem_write_done   (Mem_write_done),
      .abort_cnt        (abort_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until the selected output rises; gives up after 40.
   task automatic wait_sig(input bit want_rd, output int n);
      n = 0;
      while (((want_rd ? Data_in_Bus : Mem_write_done) == 1'b0) && (n < 40)) begin
         tick();
         n++;
      end
   endtask

   initial begin
      rst_n = 1'b0; BusRd = 1'b0; BusRdX = 1'b0; Mem_wr = 1'b0; Mem_oprn_abort = 1'b0;
      Address_Com = '0; Data_Bus_Com_in = '0;
      tick(); tick();
      chk("rst_dib",   {31'd0, Data_in_Bus},     32'd0);
      chk("rst_oe",    {31'd0, Data_Bus_Com_oe}, 32'd0);
      chk("rst_done",  {31'd0, Mem_write_done},  32'd0);
      chk("rst_out",   Data_Bus_Com_out,         32'd0);
      chk("rst_abort", {16'd0, abort_cnt},       32'd0);
      rst_n = 1'b1;
      tick();

      // Write then read back the same word.
      Mem_wr = 1'b1; Address_Com = 32'hDEADBEEC; Data_Bus_Com_in = 32'hCAFEF00D;
      tick();
      wait_sig(1'b0, cyc);
      chk("wr_latency", cyc, 32'd4);
      Mem_wr = 1'b0; Data_Bus_Com_in = '0;
      tick();
      chk("wr_done_fall", {31'd0, Mem_write_done}, 32'd0);
      tick();

      BusRd = 1'b1; Address_Com = 32'hDEADBEEC;
      tick();
      wait_sig(1'b1, cyc);
      chk("rd_latency", cyc, 32'd4);
      chk("rd_data", Data_Bus_Com_out, 32'hCAFEF00D);
      chk("rd_oe", {31'd0, Data_Bus_Com_oe}, 32'd1);
      BusRd = 1'b0;
      tick();
      chk("rd_dib_fall", {31'd0, Data_in_Bus}, 32'd0);
      chk("rd_oe_fall", {31'd0, Data_Bus_Com_oe}, 32'd0);
      tick();

      // BusRdX to an unwritten word returns its own address.
      BusRdX = 1'b1; Address_Com = 32'h00001234;
      tick();
      wait_sig(1'b1, cyc);
      chk("rdx_latency", cyc, 32'd4);
      chk("rdx_data", Data_Bus_Com_out, 32'h00001234);
      chk("rdx_oe", {31'd0, Data_Bus_Com_oe}, 32'd1);
      BusRdX = 1'b0;
      tick(); tick();

      // Abort in the second cycle of RD_WAIT.
      BusRd = 1'b1; Address_Com = 32'h00000080;
      tick();
      tick();
      Mem_oprn_abort = 1'b1;
      tick();
      Mem_oprn_abort = 1'b0; BusRd = 1'b0;
      saw_dib = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (Data_in_Bus) saw_dib = 1'b1;
         tick();
      end
      chk("rd_abort_nodata", {31'd0, saw_dib}, 32'd0);
      chk("rd_abort_cnt", {16'd0, abort_cnt}, 32'd1);

      // Abort during WR_WAIT discards the write.
      Mem_wr = 1'b1; Address_Com = 32'h00000040; Data_Bus_Com_in = 32'h11111111;
      tick();
      tick();
      Mem_oprn_abort = 1'b1;
      tick();
      Mem_oprn_abort = 1'b0; Mem_wr = 1'b0;
      tick();
      chk("wr_abort_nodone", {31'd0, Mem_write_done}, 32'd0);
      chk("wr_abort_cnt", {16'd0, abort_cnt}, 32'd2);
      tick();
      BusRd = 1'b1; Address_Com = 32'h00000040;
      tick();
      wait_sig(1'b1, cyc);
      chk("wr_abort_rd_lat", cyc, 32'd4);
      chk("wr_abort_rd_data", Data_Bus_Com_out, 32'h00000040);
      BusRd = 1'b0;
      tick(); tick();

      // Write and read together: write first, read accepted after return to idle.
      Mem_wr = 1'b1; BusRd = 1'b1; Address_Com = 32'h00000100; Data_Bus_Com_in = 32'hA5A55A5A;
      tick();
      wait_sig(1'b0, cyc);
      chk("both_wr_lat", cyc, 32'd4);
      chk("both_no_dib", {31'd0, Data_in_Bus}, 32'd0);
      Mem_wr = 1'b0;
      tick();
      chk("both_done_fall", {31'd0, Mem_write_done}, 32'd0);
      tick();
      wait_sig(1'b1, cyc);
      chk("both_rd_lat", cyc, 32'd4);
      chk("both_rd_data", Data_Bus_Com_out, 32'hA5A55A5A);
      BusRd = 1'b0;
      tick(); tick();

      // Requester drop during RD_WAIT counts as an abort.
      BusRd = 1'b1; Address_Com = 32'h00000200;
      tick();
      tick();
      BusRd = 1'b0;
      tick();
      chk("drop_cnt", {16'd0, abort_cnt}, 32'd3);
      tick(); tick(); tick();
      chk("drop_nodata", {31'd0, Data_in_Bus}, 32'd0);

      // Async reset while driving read data.
      BusRd = 1'b1; Address_Com = 32'hDEADBEEC;
      tick();
      wait_sig(1'b1, cyc);
      chk("pre_rst_data", Data_Bus_Com_out, 32'hCAFEF00D);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_dib",   {31'd0, Data_in_Bus},     32'd0);
      chk("arst_oe",    {31'd0, Data_Bus_Com_oe}, 32'd0);
      chk("arst_out",   Data_Bus_Com_out,         32'd0);
      chk("arst_abort", {16'd0, abort_cnt},       32'd0);
      BusRd = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      BusRd = 1'b1; Address_Com = 32'hDEADBEEC;
      tick();
      wait_sig(1'b1, cyc);
      chk("post_rst_lat", cyc, 32'd4);
      chk("post_rst_data", Data_Bus_Com_out, 32'hDEADBEEC);
      BusRd = 1'b0;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
